// File: rtl/sp_arb_pkg.sv
// Shared types and constants for the two-port word-to-byte memory arbiter.
package sp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int BYTES_PER_WORD = 4;

  // Lowest enabled byte lane at or above 'from'. Result is {found, lane}.
  function automatic logic [2:0] next_byte(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: fixed priority to port 0, or alternate on contention.
module rr_arb2
  import sp_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);

  // Port preferred on the next contention; it is the one not granted last.
  logic ptr;

  // Grant selection: a lone requester always wins.
  always_comb begin
    any = |req;
    gnt = PORT0;
    if (req == 2'b11) begin
      gnt = (FIXED_PRIORITY != 0) ? PORT0 : ptr;
    end else if (req[1]) begin
      gnt = PORT1;
    end
  end

  // Pointer moves to the other port after every accepted grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PORT0;
    end else if (take && any) begin
      ptr <= ~gnt;
    end
  end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Shares one byte-wide single-port memory between two word-wide request ports.
module sp_mem_arbiter
  import sp_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_read,
  input  logic        p0_write,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic [31:0] p0_rdata,
  output logic        p0_resp,
  input  logic        p1_read,
  input  logic        p1_write,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic [31:0] p1_rdata,
  output logic        p1_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_resp
);

  state_t      state, state_nxt;
  logic        gnt_port;
  logic        op_write;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic [3:0]  mask_l;
  logic [1:0]  idx;
  logic [31:0] rdata_l;

  logic [1:0]  req;
  logic        arb_gnt, arb_any;
  logic        sel_rd, sel_wr;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_mask;
  logic [2:0]  first_nb, next_nb;

  assign req = {p1_read | p1_write, p0_read | p0_write};

  rr_arb2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .take(state == IDLE),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // Request of the winning port; read wins over write, reads touch every lane.
  always_comb begin
    sel_rd    = (arb_gnt == PORT1) ? p1_read  : p0_read;
    sel_wr    = (arb_gnt == PORT1) ? p1_write : p0_write;
    sel_addr  = (arb_gnt == PORT1) ? p1_addr  : p0_addr;
    sel_wdata = (arb_gnt == PORT1) ? p1_wdata : p0_wdata;
    sel_mask  = sel_rd ? 4'hF : ((arb_gnt == PORT1) ? p1_wmask : p0_wmask);
    first_nb  = next_byte(sel_mask, 3'd0);
    next_nb   = next_byte(mask_l, {1'b0, idx} + 3'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = first_nb[2] ? ISSUE : DONE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_resp) state_nxt = next_nb[2] ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: capture the granted request, then walk the byte lanes.
  always_ff @(posedge clk) begin
    if (state == IDLE && arb_any) begin
      gnt_port <= arb_gnt;
      op_write <= sel_wr && !sel_rd;
      addr_l   <= sel_addr;
      wdata_l  <= sel_wdata;
      mask_l   <= sel_mask;
      idx      <= first_nb[1:0];
    end else if (state == WAIT && mem_resp) begin
      if (!op_write) rdata_l[{idx, 3'b000} +: 8] <= mem_rdata;
      idx <= next_nb[1:0];
    end
  end

  // Outputs decode from state so they are quiet outside their owning state.
  always_comb begin
    mem_read  = (state == ISSUE) && !op_write;
    mem_write = (state == ISSUE) && op_write;
    mem_addr  = (state == ISSUE) ? ((addr_l & ~32'h3) + 32'(idx)) : 32'h0;
    mem_wdata = (state == ISSUE) ? wdata_l[{idx, 3'b000} +: 8] : 8'h0;
    p0_resp   = (state == DONE) && (gnt_port == PORT0);
    p1_resp   = (state == DONE) && (gnt_port == PORT1);
    p0_rdata  = (p0_resp && !op_write) ? rdata_l : 32'h0;
    p1_rdata  = (p1_resp && !op_write) ? rdata_l : 32'h0;
  end

endmodule

// File: doc/sp_mem_arbiter.md
SP_MEM_ARBITER -- requirements
Module: sp_mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin between ports, 1 = port 0 always wins.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 p0_read / p0_write  input  1 each  port 0 word read / write request, held until p0_resp.
REQ-005 p0_addr  input  32  port 0 byte address; bits [1:0] ignored, word-aligned.
REQ-006 p0_wdata  input  32  port 0 write data, byte i on bits [8i+7:8i].
REQ-007 p0_wmask  input  4  port 0 byte enables for writes.
REQ-008 p0_rdata  output  32  port 0 read data, valid only while p0_resp=1.
REQ-009 p0_resp  output  1  port 0 single-cycle completion pulse.
REQ-010 p1_read, p1_write, p1_addr, p1_wdata, p1_wmask, p1_rdata, p1_resp SHALL be identical to the port 0 signals in direction, width and meaning, for port 1.
REQ-011 mem_read / mem_write  output  1 each  byte read / write strobe to the single-port memory.
REQ-012 mem_addr  output  32  byte address to memory.
REQ-013 mem_wdata  output  8  write byte.
REQ-014 mem_rdata  input  8  read byte, valid while mem_resp=1.
REQ-015 mem_resp  input  1  memory completion; arrives one or more cycles after a strobe.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-017 IDLE: if any port requests, grant one, latch op/addr/wdata/wmask, set byte index to the first byte to access, and go to ISSUE. With no requests, stay in IDLE.
REQ-018 Arbitration with both ports requesting in IDLE: FIXED_PRIORITY=1 grants port 0. FIXED_PRIORITY=0 grants the port not granted last; the first contention after reset goes to port 0.
REQ-019 ISSUE SHALL assert exactly one of mem_read/mem_write for exactly one cycle, with mem_addr = {addr[31:2],2'b00} + index and mem_wdata = wdata byte[index], then go to WAIT.
REQ-020 WAIT SHALL hold mem_read=mem_write=0 until mem_resp=1. On mem_resp=1 for a read, it captures mem_rdata into rdata byte[index]. It then advances to the next required byte (ISSUE) or, after the last byte, goes to DONE.
REQ-021 Reads SHALL access all 4 bytes in order 0..3. Writes SHALL access only bytes with wmask=1, in ascending order.
REQ-022 A write with wmask=4'b0000 SHALL go IDLE->DONE with no memory access.
REQ-023 DONE SHALL assert the granted port's resp (and rdata for reads) for exactly one cycle, then return to IDLE. The other port's resp SHALL stay 0.
REQ-024 Requesters deassert read/write in the cycle after resp. A request held beyond that is treated as a new request.
REQ-025 read and write both high on one port SHALL be treated as a read.
REQ-026 Request signals that change while a port is granted SHALL be ignored until the next IDLE.
REQ-027 A mem_resp arriving outside WAIT SHALL be ignored.
REQ-028 Latency with a 1-cycle memory SHALL be: read = 9 cycles from request-sampling edge to resp; write = 1 + 2*popcount(wmask) cycles.

Reset
REQ-029 While rst=1, state SHALL be IDLE, round-robin pointer SHALL be port 0, and all outputs (resp, rdata, mem_read, mem_write, mem_addr, mem_wdata) SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon it with no resp; partially written bytes stay written.

Structure
REQ-031 A shared package sp_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, DONE), port-id constants PORT0/PORT1, and BYTES_PER_WORD=4.
REQ-032 Arbitration SHALL live in one sub-module, rr_arb2: a 2-request grant with a last-grant register and a FIXED_PRIORITY parameter.

Verification
REQ-033 Memory word 0x100 holds 0xDDCCBBAA; p0_read addr 0x100 -> mem_read at 0x100..0x103, p0_rdata=0xDDCCBBAA with p0_resp at cycle 9.
REQ-034 p1_write addr 0x203, wdata 0x11223344, wmask 4'b0101 -> only 0x200<=0x44 and 0x202<=0x22 written; p1_resp at cycle 5.
REQ-035 p0_read and p1_read asserted together for 3 back-to-back transactions, FIXED_PRIORITY=0 -> grants p0,p1,p0. With FIXED_PRIORITY=1 -> grants p0,p0,p0.
REQ-036 Write with wmask=0 -> no mem strobe; resp at cycle 1.
REQ-037 rst asserted in WAIT of byte 2 -> all outputs 0 next cycle, no resp; the next read completes normally.
REQ-038 Memory with 3-cycle resp delay -> exactly one strobe cycle per byte, and the read still returns the correct word.
